// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core. It sequences the shared
// memory, ALU, register file and PC through the fetch/decode/execute states.
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               RegWrite,
    output logic [STATE_W-1:0] state
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        nxt_state = S_FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        RegWrite  = 1'b0;
        unique case (cur_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
                nxt_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXECR;
                    OP_I:         nxt_state = S_EXECI;
                    OP_JAL:       nxt_state = S_JAL;
                    OP_BEQ:       nxt_state = S_BEQ;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                nxt_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA   = 2'b10;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                nxt_state = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase

        // Reset aborts the instruction: Fetch selects, but nothing is written
        if (reset) begin
            pc_update = 1'b0;
            branch    = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            ResultSrc = 2'b10;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b10;
            alu_op    = 2'b00;
            RegWrite  = 1'b0;
        end

        PCWrite = pc_update | (branch & zero);
    end

    // ALU decoder; op[5] separates R-type sub from addi with imm bit 10 set
    always_comb begin
        ALUControl = ALU_ADD;
        unique case (alu_op)
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                unique case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        unique case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign state = STATE_W'(cur_state);

    a_write_enables_exclusive: assert property (@(posedge clk)
        $onehot0({IRWrite, MemWrite, RegWrite}));

    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        cur_state <= S_BEQ);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a driver issues instructions and
// queues the expected per-cycle controls; a monitor pops and compares them.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       rw;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t exp_q[$];
    rec_t seq[$];

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .state(state)
    );

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OP_SW) return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Operation the ALU must perform for an arithmetic instruction
    function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == OP_R && f7) ? SUB : ADD;
            3'd2:    return SLT;
            3'd6:    return OR_;
            3'd7:    return AND_;
            default: return ADD;
        endcase
    endfunction

    function automatic rec_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                                input logic mw, input logic irw, input logic [1:0] rs,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [2:0] alu, input logic rw, input logic [6:0] o);
        rec_t r;
        r = '{st, pcw, adr, mw, irw, rs, sa, sb, imm_of(o), alu, rw};
        return r;
    endfunction

    function automatic rec_t rst_rec(input logic [3:0] st, input logic [6:0] o);
        return mk(st, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD, 0, o);
    endfunction

    // Cycle-by-cycle expected controls for one instruction, Fetch onward
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        rec_t wb;
        rec_t memadr;
        seq.delete();
        wb     = mk(7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 1, o);
        memadr = mk(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 0, o);
        seq.push_back(mk(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, ADD, 0, o));
        seq.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, 0, o));
        case (o)
            OP_LW: begin
                seq.push_back(memadr);
                seq.push_back(mk(3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0, o));
                seq.push_back(mk(4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, ADD, 1, o));
            end
            OP_SW: begin
                seq.push_back(memadr);
                seq.push_back(mk(5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD, 0, o));
            end
            OP_R: begin
                seq.push_back(mk(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_fn(o, f3, f7), 0, o));
                seq.push_back(wb);
            end
            OP_I: begin
                seq.push_back(mk(8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_fn(o, f3, f7), 0, o));
                seq.push_back(wb);
            end
            OP_JAL: begin
                seq.push_back(mk(9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD, 0, o));
                seq.push_back(wb);
            end
            OP_BEQ: seq.push_back(mk(10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, SUB, 0, o));
            default: ;
        endcase
    endtask

    // zmode: 0/1 forces zero, 2 randomizes it per cycle; abort_at < 0 runs to completion
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input int zmode, input int abort_at);
        rec_t e;
        build(o, f3, f7);
        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk);
            #1;
            op       = o;
            funct3   = f3;
            funct7b5 = f7;
            zero     = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            e        = seq[i];
            if (i == abort_at) begin
                reset = 1'b1;
                exp_q.push_back(rst_rec(e.st, o));
                break;
            end
            reset = 1'b0;
            if (e.st == 4'd10) e.pcw = zero;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        rec_t a;
        rec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, RegWrite};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_ctl exp_state=%0d op=%b: got st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b imm=%b alu=%b rw=%b, expected st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b imm=%b alu=%b rw=%b",
                         e.st, op, a.st, a.pcw, a.adr, a.mw, a.irw, a.rs, a.sa, a.sb, a.imm, a.alu, a.rw,
                         e.st, e.pcw, e.adr, e.mw, e.irw, e.rs, e.sa, e.sb, e.imm, e.alu, e.rw);
            end
        end
    end

    initial begin
        logic [6:0] ops [6];
        logic [2:0] f3s [5];
        logic [6:0] o;
        logic [2:0] f3;
        int         ab;
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7, 3'd3};

        reset    = 1'b1;
        op       = OP_LW;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(rst_rec(4'd0, OP_LW));
        end

        run(OP_LW,  3'd2, 1'b0, 2, -1);
        run(OP_SW,  3'd2, 1'b0, 2, -1);
        run(OP_R,   3'd0, 1'b1, 2, -1);
        run(OP_R,   3'd0, 1'b0, 2, -1);
        run(OP_R,   3'd2, 1'b0, 2, -1);
        run(OP_R,   3'd6, 1'b0, 2, -1);
        run(OP_R,   3'd7, 1'b1, 2, -1);
        run(OP_I,   3'd0, 1'b1, 2, -1);
        run(OP_BEQ, 3'd0, 1'b0, 1, -1);
        run(OP_BEQ, 3'd0, 1'b0, 0, -1);
        run(OP_JAL, 3'd0, 1'b0, 2, -1);
        run(7'b0000000, 3'd0, 1'b0, 2, -1);
        run(OP_SW,  3'd0, 1'b0, 2, 3);
        run(OP_LW,  3'd0, 1'b0, 2, 0);

        for (int n = 0; n < 300; n++) begin
            o  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 4)];
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run(o, f3, 1'($urandom_range(0, 1)), 2, ab);
        end

        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
